// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard frame receiver: synchronizes the pins, decodes 11-bit frames,
// and queues validated scancodes in a small FIFO that is read through the KBDR path.
module ps2_keyboard_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          Pop,
  input  logic                          Clear_Ovf,
  output logic [15:0]                   Data_FromKeyboard,
  output logic                          Ready,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          Frame_Err,
  output logic                          Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Pin conditioning; flops idle high to match the PS/2 bus idle level
  logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2, fe;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_d <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK; clk_s2 <= clk_s1; clk_d <= clk_s2;
      dat_s1 <= PS2_DAT; dat_s2 <= dat_s1;
    end
  end

  assign fe = clk_d & ~clk_s2;

  state_t          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            push, err;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bcnt_q    <= '0;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      Frame_Err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bcnt_q    <= bcnt_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      Frame_Err <= err;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    push    = 1'b0;
    err     = 1'b0;
    tcnt_d  = (fe || state_q == IDLE) ? '0 : tcnt_q + 1'b1;
    // A clock edge arriving on the last timeout cycle still counts as progress
    if (state_q != IDLE && !fe && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      sh_d    = '0;
      tcnt_d  = '0;
      err     = 1'b1;
    end else if (fe) begin
      case (state_q)
        IDLE: if (!dat_s2) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          sh_d   = {dat_s2, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s2 && (^sh_q ^ par_q)) push = 1'b1;
          else                           err  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scancode FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          full, empty, do_pop, do_push, ovf_set;

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = Pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      Overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      if (ovf_set)        Overflow <= 1'b1;
      else if (Clear_Ovf) Overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr] <= sh_q;
  end

  assign Count             = cnt;
  assign Ready             = ~empty;
  assign Data_FromKeyboard = empty ? 16'h0000 : {8'h00, mem[rptr]};
endmodule
